// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch FSM state encoding for the 4-stage pipeline.
package isa_pkg;

   localparam int INSTR_W = 8;

   localparam logic [INSTR_W-1:0] HALT_OP = 8'hFF;
   localparam logic [INSTR_W-1:0] NOP_OP  = 8'h00;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x INSTR_W array, synchronous write, combinational read.
module instr_mem
   import isa_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [INSTR_W-1:0] mem [DEPTH];

   // NOTE: no reset on the array; the program must survive a reset so it can be re-run.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, LOAD/RUN/HALT FSM and registered IF/ID outputs.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
   parameter int                              ADDR_W  = 5,
   parameter logic [isa_pkg::INSTR_W-1:0]     HALT_OP = isa_pkg::HALT_OP,
   parameter logic [isa_pkg::INSTR_W-1:0]     NOP_OP  = isa_pkg::NOP_OP
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          imem_we,
   input  logic [ADDR_W-1:0]             imem_waddr,
   input  logic [isa_pkg::INSTR_W-1:0]   imem_wdata,
   input  logic                          start,
   input  logic                          stall,
   input  logic                          br_taken,
   input  logic [ADDR_W-1:0]             br_target,
   output logic [isa_pkg::INSTR_W-1:0]   ins_out,
   output logic [ADDR_W-1:0]             pc_out,
   output logic                          ins_valid,
   output logic                          halted
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [15:0]                   fetch_count,
   output logic [15:0]                   stall_count
`endif
);

   import isa_pkg::*;

   fetch_state_t       state;
   logic [ADDR_W-1:0]  pc;
   logic [INSTR_W-1:0] mem_rdata;
   logic               fetch_go;

   instr_mem #(.ADDR_W(ADDR_W)) u_imem (
      .clk   (clk),
      .we    (imem_we && (state == LOAD)),
      .waddr (imem_waddr),
      .wdata (imem_wdata),
      .raddr (pc),
      .rdata (mem_rdata)
   );

   // A normal fetch: running, not squashed by a branch, not frozen by a stall.
   assign fetch_go = (state == RUN) && !br_taken && !stall;

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= LOAD;
         pc        <= '0;
         ins_out   <= NOP_OP;
         pc_out    <= '0;
         ins_valid <= 1'b0;
         halted    <= 1'b0;
      end else begin
         unique case (state)
            LOAD: begin
               if (start) state <= RUN;
            end
            RUN: begin
               if (br_taken) begin
                  pc        <= br_target;
                  ins_out   <= NOP_OP;
                  ins_valid <= 1'b0;
               end else if (!stall) begin
                  ins_out   <= mem_rdata;
                  pc_out    <= pc;
                  ins_valid <= 1'b1;
                  pc        <= pc + 1'b1;
                  // The halt opcode itself is issued; fetch stops from the next edge.
                  if (mem_rdata == HALT_OP) state <= HALT;
               end
            end
            HALT: begin
               ins_out   <= NOP_OP;
               ins_valid <= 1'b0;
               halted    <= 1'b1;
            end
            default: state <= LOAD;
         endcase
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic stall_go;
   assign stall_go = (state == RUN) && stall && !br_taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (fetch_go && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
         if (stall_go && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (ADDR_W=5).
module tb_instr_fetch_unit;

   localparam int ADDR_W = 5;

   logic              clk;
   logic              reset;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [7:0]        imem_wdata;
   logic              start;
   logic              stall;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic [7:0]        ins_out;
   logic [ADDR_W-1:0] pc_out;
   logic              ins_valid;
   logic              halted;
`ifdef IFU_PERF_CNT_EN
   logic [15:0]       fetch_count;
   logic [15:0]       stall_count;
`endif

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .start      (start),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .ins_out    (ins_out),
      .pc_out     (pc_out),
      .ins_valid  (ins_valid),
      .halted     (halted)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_count(fetch_count),
      .stall_count(stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] ins, input logic [ADDR_W-1:0] pc,
                            input logic vld, input logic hlt);
      check({tag, ".ins"},    32'(ins_out),   32'(ins));
      check({tag, ".pc"},     32'(pc_out),    32'(pc));
      check({tag, ".valid"},  32'(ins_valid), 32'(vld));
      check({tag, ".halted"}, 32'(halted),    32'(hlt));
   endtask

   // Advance one rising edge, then settle 1 time unit away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      imem_we    = 1'b1;
      imem_waddr = a;
      imem_wdata = d;
      step();
      imem_we    = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Asynchronous reset asserted and released between clock edges.
   task automatic async_reset();
      #3 reset = 1'b1;
      #1 check_out("async_rst", 8'h00, '0, 1'b0, 1'b0);
      step();
      #2 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      #2 check_out("reset", 8'h00, '0, 1'b0, 1'b0);
      #10 reset = 1'b0;

      // Program load, including outputs holding reset values while loading.
      write_mem(5'd0,  8'h11);
      write_mem(5'd1,  8'h22);
      write_mem(5'd2,  8'h33);
      write_mem(5'd3,  8'h44);
      write_mem(5'd10, 8'hAA);
      write_mem(5'd11, 8'hBB);
      write_mem(5'd31, 8'hEE);
      stall = 1'b1; br_taken = 1'b1; br_target = 5'd7;
      step();
      stall = 1'b0; br_taken = 1'b0;
      check_out("load_hold", 8'h00, '0, 1'b0, 1'b0);

      pulse_start();
      check_out("enter_run", 8'h00, '0, 1'b0, 1'b0);
      step(); check_out("fetch0", 8'h11, 5'd0, 1'b1, 1'b0);
      step(); check_out("fetch1", 8'h22, 5'd1, 1'b1, 1'b0);

      // Two stalled cycles, with a write attempt that must be ignored in RUN.
      stall = 1'b1; imem_we = 1'b1; imem_waddr = 5'd0; imem_wdata = 8'h99;
      step(); check_out("stall_a", 8'h22, 5'd1, 1'b1, 1'b0);
      step(); check_out("stall_b", 8'h22, 5'd1, 1'b1, 1'b0);
      stall = 1'b0; imem_we = 1'b0;
      step(); check_out("release", 8'h33, 5'd2, 1'b1, 1'b0);
      step(); check_out("fetch3",  8'h44, 5'd3, 1'b1, 1'b0);

      // Branch outranks a simultaneous stall and squashes the slot.
      br_taken = 1'b1; br_target = 5'd10; stall = 1'b1;
      step(); check_out("br_squash", 8'h00, 5'd3, 1'b0, 1'b0);
      br_taken = 1'b0; stall = 1'b0;
      step(); check_out("br_tgt",  8'hAA, 5'd10, 1'b1, 1'b0);
      step(); check_out("br_next", 8'hBB, 5'd11, 1'b1, 1'b0);

      // PC wrap 31 -> 0; mem[0] still holds the value written in LOAD.
      br_taken = 1'b1; br_target = 5'd31;
      step(); check("wrap_squash.valid", 32'(ins_valid), 32'd0);
      br_taken = 1'b0;
      step(); check_out("wrap31", 8'hEE, 5'd31, 1'b1, 1'b0);
      step(); check_out("wrap0",  8'h11, 5'd0,  1'b1, 1'b0);

      // Mid-run reset, then re-run from address 0 with memory preserved.
      async_reset();
      check_out("post_rst_load", 8'h00, '0, 1'b0, 1'b0);
      pulse_start();
      step(); check_out("rerun0", 8'h11, 5'd0, 1'b1, 1'b0);
      step(); check_out("rerun1", 8'h22, 5'd1, 1'b1, 1'b0);

`ifdef IFU_PERF_CNT_EN
      async_reset();
      check("perf_rst.fetch", 32'(fetch_count), 32'd0);
      check("perf_rst.stall", 32'(stall_count), 32'd0);
      pulse_start();
      step(); step();
      stall = 1'b1;
      step(); step(); step();
      stall = 1'b0;
      step(); check_out("perf_f2", 8'h33, 5'd2, 1'b1, 1'b0);
      br_taken = 1'b1; br_target = 5'd10; stall = 1'b1;
      step();
      br_taken = 1'b0; stall = 1'b0;
      step(); step();
      check("perf.fetch", 32'(fetch_count), 32'd5);
      check("perf.stall", 32'(stall_count), 32'd3);
`endif

      // Halt: rewrite mem[2] in LOAD, run into it.
      async_reset();
      write_mem(5'd2, 8'hFF);
      pulse_start();
      step(); check_out("h_fetch0", 8'h11, 5'd0, 1'b1, 1'b0);
      step(); check_out("h_fetch1", 8'h22, 5'd1, 1'b1, 1'b0);
      step(); check_out("h_issue",  8'hFF, 5'd2, 1'b1, 1'b0);
      step(); check_out("h_enter",  8'h00, 5'd2, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         br_taken  = (i % 2) == 0;
         br_target = 5'd10;
         start     = (i == 3);
         stall     = (i % 3) == 0;
         step();
         check_out($sformatf("h_frozen%0d", i), 8'h00, 5'd2, 1'b0, 1'b1);
      end
      br_taken = 1'b0; start = 1'b0; stall = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 4-stage pipelined processor; sits directly upstream of the IF/ID pipeline register and drives its 8-bit instruction input.
- Holds the program counter and a writable instruction memory. Memory is loaded before execution.
- Fetches one 8-bit instruction per cycle and supports stall, branch redirect with squash, and halt detection.

Parameters:
- ADDR_W, 5, PC/instruction-memory address width; DEPTH = 2**ADDR_W.
- HALT_OP, 8'hFF, instruction encoding that stops fetch.
- NOP_OP, 8'h00, encoding driven on ins_out during bubbles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_we  in  1  instruction-memory write enable; honoured only in LOAD.
- imem_waddr  in  ADDR_W  write address.
- imem_wdata  in  8  write data.
- start  in  1  single-cycle pulse; LOAD to RUN.
- stall  in  1  hazard stall from downstream; freezes the fetch stage.
- br_taken  in  1  redirect request from the execute stage.
- br_target  in  ADDR_W  redirect PC.
- ins_out  out  8  fetched instruction; feeds the IF/ID register.
- pc_out  out  ADDR_W  address of ins_out.
- ins_valid  out  1  ins_out is a real instruction, not a bubble.
- halted  out  1  fetch has stopped on HALT_OP.

Behaviour:
- Reset (async, immediate):
  - state=LOAD, pc=0, ins_out=NOP_OP, pc_out=0, ins_valid=0, halted=0.
  - Memory contents are not cleared.
- FSM states: LOAD, RUN, HALT.
  - LOAD: imem_we=1 writes mem[imem_waddr] <= imem_wdata at the clock edge. Outputs hold their reset values. stall and br_taken are ignored. start=1 moves to RUN. A write in the same cycle as start still completes.
  - RUN: imem_we is ignored. All outputs are registered, so ins_out/pc_out reflect the fetch one cycle later.
  - HALT: pc holds, ins_out=NOP_OP, ins_valid=0, halted=1. State is sticky until reset; start, br_taken and stall are ignored.
- RUN per-cycle priority (highest first):
  1. br_taken=1: pc <= br_target; ins_out <= NOP_OP; ins_valid <= 0 (squash). Applies even if stall=1.
  2. stall=1: pc, ins_out, pc_out and ins_valid all hold.
  3. Normal: ins_out <= mem[pc]; pc_out <= pc; ins_valid <= 1; pc <= pc+1 mod DEPTH (DEPTH-1 wraps to 0).
- Halt detection:
  - In the normal case, if mem[pc]==HALT_OP, the HALT_OP is still issued with ins_valid=1 that cycle, then state goes to HALT.
  - From the next edge, outputs take their HALT values.
  - HALT_OP is not detected when the fetch is squashed by br_taken or frozen by stall.
- First fetch after start: the cycle after entering RUN fetches mem[0]. pc_out=0 with ins_valid=1 appears one edge later.
- Reset mid-RUN: returns to LOAD immediately and the program is preserved. Asserting start again re-runs it from address 0.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [15:0], reset to 0, counting cycles in which ins_valid is set by a normal fetch.
  - Adds output stall_count [15:0], reset to 0, counting RUN cycles with stall=1 and br_taken=0.
  - Both counters saturate at 16'hFFFF.
- Undefined: these ports and their logic do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package (isa_pkg): HALT_OP and NOP_OP constants, instruction width (8), and the FSM state encoding (LOAD=2'd0, RUN=2'd1, HALT=2'd2).
- One sub-module, instr_mem: DEPTH x 8 array with synchronous write and combinational read. The fetch unit owns the PC, FSM and output registers.

Test Plan:
- Load: write mem[0..3]=8'h11,8'h22,8'h33,8'h44, pulse start, then 4 cycles -> ins_out sequence 11,22,33,44 with pc_out 0..3 and ins_valid=1 each cycle. Writes attempted during RUN leave memory unchanged.
- Stall: stall=1 for 2 cycles while ins_out=8'h22/pc_out=1 -> both outputs hold 2 cycles. Release -> 8'h33/pc_out=2 with no skipped or duplicated address.
- Branch with stall: br_taken=1, br_target=5'd10, stall=1 in the same cycle -> next cycle ins_out=NOP, ins_valid=0. Following cycle ins_out=mem[10], pc_out=10.
- Halt: mem[2]=8'hFF -> cycle with ins_out=FF/pc_out=2/ins_valid=1, then halted=1, ins_valid=0, outputs frozen for 10+ cycles. br_taken and start are ignored.
- Wrap and async reset: run with pc=31 -> ins_out=mem[31] then mem[0]. Assert reset between clock edges -> outputs go to reset values immediately, state=LOAD. Start again -> memory preserved, mem[0] re-fetched.
- IFU_PERF_CNT_EN build: 5 fetches, 3 stall cycles and 1 branch -> fetch_count=5, stall_count=3.
